prob_token_sampler: RTL and testbench

- Consumer at the far end of the softmax path: accepts one `VECTOR_LEN`-element vector of 8-bit unsigned probabilities (nominal sum 256, tolerated 230–280), exactly as `softmax_unit` emits on `prob_out`/`valid_out`.
- Draws one index by inverse-CDF sampling against a free-running LFSR.
- Returns the selected token index and its probability; feeds the token-select stage after the final softmax.

---
 rtl/prob_token_sampler.sv | 204 ++++++++++++++++++++
 tb/tb_prob_token_sampler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/prob_token_sampler.sv
// prob_token_sampler: draws one token index from a vector of 8-bit probabilities
// by inverse-CDF sampling against a free-running 16-bit Galois LFSR.
// Optional macro PROB_SAMPLER_GREEDY_EN adds a greedy_in port that selects
// arg-max mode (ties go to the lowest index) instead of random sampling.
module prob_token_sampler #(
  parameter int          VECTOR_LEN = 4,
  parameter int          PROB_WIDTH = 8,
  parameter int          IDX_WIDTH  = $clog2(VECTOR_LEN),
  parameter int          SUM_WIDTH  = PROB_WIDTH + $clog2(VECTOR_LEN),
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             valid_in,
  input  logic [VECTOR_LEN*PROB_WIDTH-1:0] prob_in,
`ifdef PROB_SAMPLER_GREEDY_EN
  input  logic                             greedy_in,
`endif
  output logic                             ready_out,
  output logic [IDX_WIDTH-1:0]             token_out,
  output logic [PROB_WIDTH-1:0]            token_prob,
  output logic                             zero_sum,
  output logic                             valid_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    DRAW = 2'd2,
    SCAN = 2'd3
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(VECTOR_LEN - 1);
  localparam logic [15:0]          LFSR_MASK = 16'hB400;

  state_t                          state_q, state_d;
  logic [VECTOR_LEN*PROB_WIDTH-1:0] probs_q, probs_d;
  logic [SUM_WIDTH-1:0]            total_q, total_d;
  logic [SUM_WIDTH-1:0]            thresh_q, thresh_d;
  logic [SUM_WIDTH-1:0]            cum_q, cum_d;
  logic [IDX_WIDTH-1:0]            idx_q, idx_d;
  logic [IDX_WIDTH-1:0]            token_q, token_d;
  logic [PROB_WIDTH-1:0]           tokenProb_q, tokenProb_d;
  logic                            zeroSum_q, zeroSum_d;
  logic                            valid_q, valid_d;
  logic                            greedy_q, greedy_d;
  logic [PROB_WIDTH-1:0]           best_q, best_d;
  logic [IDX_WIDTH-1:0]            bestIdx_q, bestIdx_d;
  logic [15:0]                     lfsr_q, lfsr_d;

  logic [PROB_WIDTH-1:0]           elem [VECTOR_LEN];
  logic [PROB_WIDTH-1:0]           curProb;
  logic [SUM_WIDTH-1:0]            curExt;
  logic [SUM_WIDTH-1:0]            cumNext;
  logic                            greedyIn;

`ifdef PROB_SAMPLER_GREEDY_EN
  assign greedyIn = greedy_in;
`else
  assign greedyIn = 1'b0;
`endif

  // Unpack the captured vector and pick out the element addressed by the walk index
  always_comb begin
    for (int i = 0; i < VECTOR_LEN; i++) begin
      elem[i] = probs_q[i*PROB_WIDTH +: PROB_WIDTH];
    end
    curProb = elem[idx_q];
    curExt  = SUM_WIDTH'(curProb);
    cumNext = cum_q + curExt;
  end

  // Next-state logic for the sampler FSM, the LFSR and all result registers
  always_comb begin
    state_d     = state_q;
    probs_d     = probs_q;
    total_d     = total_q;
    thresh_d    = thresh_q;
    cum_d       = cum_q;
    idx_d       = idx_q;
    token_d     = token_q;
    tokenProb_d = tokenProb_q;
    zeroSum_d   = zeroSum_q;
    valid_d     = 1'b0;
    greedy_d    = greedy_q;
    best_d      = best_q;
    bestIdx_d   = bestIdx_q;
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          probs_d  = prob_in;
          total_d  = '0;
          idx_d    = '0;
          greedy_d = greedyIn;
          state_d  = SUM;
        end
      end

      SUM: begin
        total_d = total_q + curExt;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DRAW;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DRAW: begin
        cum_d     = '0;
        idx_d     = '0;
        best_d    = '0;
        bestIdx_d = '0;
        if (greedy_q) begin
          state_d = SCAN;
        end else if (total_q == '0) begin
          token_d     = '0;
          tokenProb_d = '0;
          zeroSum_d   = 1'b1;
          valid_d     = 1'b1;
          state_d     = IDLE;
        end else begin
          thresh_d = SUM_WIDTH'(({8'h00, total_q} * {{SUM_WIDTH{1'b0}}, lfsr_q[7:0]}) >> 8);
          state_d  = SCAN;
        end
      end

      SCAN: begin
        if (greedy_q) begin
          if (curProb > best_q) begin
            best_d    = curProb;
            bestIdx_d = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            token_d     = (curProb > best_q) ? idx_q : bestIdx_q;
            tokenProb_d = (curProb > best_q) ? curProb : best_q;
            zeroSum_d   = (total_q == '0);
            valid_d     = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          if ((thresh_q < cumNext) || (idx_q == LAST_IDX)) begin
            token_d     = idx_q;
            tokenProb_d = curProb;
            zeroSum_d   = 1'b0;
            valid_d     = 1'b1;
            state_d     = IDLE;
          end else begin
            cum_d = cumNext;
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared (LFSR seeded) by the async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      probs_q     <= '0;
      total_q     <= '0;
      thresh_q    <= '0;
      cum_q       <= '0;
      idx_q       <= '0;
      token_q     <= '0;
      tokenProb_q <= '0;
      zeroSum_q   <= 1'b0;
      valid_q     <= 1'b0;
      greedy_q    <= 1'b0;
      best_q      <= '0;
      bestIdx_q   <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      probs_q     <= probs_d;
      total_q     <= total_d;
      thresh_q    <= thresh_d;
      cum_q       <= cum_d;
      idx_q       <= idx_d;
      token_q     <= token_d;
      tokenProb_q <= tokenProb_d;
      zeroSum_q   <= zeroSum_d;
      valid_q     <= valid_d;
      greedy_q    <= greedy_d;
      best_q      <= best_d;
      bestIdx_q   <= bestIdx_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign ready_out  = (state_q == IDLE);
  assign token_out  = token_q;
  assign token_prob = tokenProb_q;
  assign zero_sum   = zeroSum_q;
  assign valid_out  = valid_q;

endmodule

// File: tb/tb_prob_token_sampler.sv
// tb_prob_token_sampler: directed checks of prob_token_sampler with
// hand-computed expected tokens, latencies and draw-count ranges.
module tb_prob_token_sampler;

  localparam int VL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] prob_in;
  logic        ready_out;
  logic [1:0]  token_out;
  logic [7:0]  token_prob;
  logic        zero_sum;
  logic        valid_out;
`ifdef PROB_SAMPLER_GREEDY_EN
  logic        greedyMode;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  int          burstCount [4];
  int          burstPulses;
  int          badIntervals;
  int          extraPulses;
  int          lat;
  logic [1:0]  tok;
  logic [7:0]  tprob;
  logic        zs;
  int          rstPulses;

  prob_token_sampler #(
    .VECTOR_LEN(VL),
    .PROB_WIDTH(8),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .prob_in   (prob_in),
`ifdef PROB_SAMPLER_GREEDY_EN
    .greedy_in (greedyMode),
`endif
    .ready_out (ready_out),
    .token_out (token_out),
    .token_prob(token_prob),
    .zero_sum  (zero_sum),
    .valid_out (valid_out)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    @(negedge clk);
    while (ready_out !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready_out !== 1'b1) checkOutput("readyTimeout", 32'(ready_out), 1);
  endtask

  // One vector, one result: measures edges from the accept edge to valid_out
  task automatic applyStimulus(input logic [31:0] vec);
    waitReady();
    prob_in  = vec;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid_out === 1'b1) break;
    end
    if (valid_out !== 1'b1) checkOutput("resultTimeout", 32'(valid_out), 1);
    tok   = token_out;
    tprob = token_prob;
    zs    = zero_sum;
    @(posedge clk);
    #1;
    checkOutput("pulseWidth", 32'(valid_out), 0);
  endtask

  // Back-to-back draws with valid_in held high; tallies tokens and pulse spacing
  task automatic runBurst(input logic [31:0] vec, input int n);
    int cyc;
    int last;
    waitReady();
    for (int i = 0; i < 4; i++) burstCount[i] = 0;
    burstPulses  = 0;
    badIntervals = 0;
    extraPulses  = 0;
    cyc          = 0;
    last         = -1;
    prob_in      = vec;
    valid_in     = 1'b1;
    while (burstPulses < n && cyc < n * 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid_out === 1'b1) begin
        burstCount[token_out]++;
        burstPulses++;
        if (last >= 0 && ((cyc - last) < VL + 3 || (cyc - last) > 2 * VL + 2)) badIntervals++;
        last = cyc;
        if (burstPulses == n) valid_in = 1'b0;
      end
    end
    valid_in = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid_out === 1'b1) extraPulses++;
    end
    checkOutput("burstPulses", 32'(burstPulses), 32'(n));
    checkOutput("burstExtra", 32'(extraPulses), 0);
    checkOutput("burstSpacing", 32'(badIntervals), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    prob_in  = '0;
`ifdef PROB_SAMPLER_GREEDY_EN
    greedyMode = 1'b0;
`endif
    #2;
    checkOutput("rstToken", 32'(token_out), 0);
    checkOutput("rstProb", 32'(token_prob), 0);
    checkOutput("rstZero", 32'(zero_sum), 0);
    checkOutput("rstValid", 32'(valid_out), 0);
    checkOutput("rstReady", 32'(ready_out), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // [0,0,0,0]: zero-sum result after E(VL+1)
    applyStimulus(32'h00000000);
    checkOutput("zeroToken", 32'(tok), 0);
    checkOutput("zeroProb", 32'(tprob), 0);
    checkOutput("zeroFlag", 32'(zs), 1);
    checkOutput("zeroLatency", 32'(lat), 32'(VL + 1));

    // [255,0,0,0]: index 0 always, after E(VL+2)
    applyStimulus(32'h000000FF);
    checkOutput("firstToken", 32'(tok), 0);
    checkOutput("firstProb", 32'(tprob), 255);
    checkOutput("firstZero", 32'(zs), 0);
    checkOutput("firstLatency", 32'(lat), 32'(VL + 2));

    // [0,0,0,255] x20: index 3 every draw, after E(VL+5)
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32'hFF000000);
      checkOutput($sformatf("oneHotToken%0d", i), 32'(tok), 3);
      checkOutput($sformatf("oneHotProb%0d", i), 32'(tprob), 255);
      checkOutput($sformatf("oneHotZero%0d", i), 32'(zs), 0);
      checkOutput($sformatf("oneHotLatency%0d", i), 32'(lat), 32'(VL + 5));
    end

    // Uniform [64,64,64,64] x400 back-to-back
    runBurst(32'h40404040, 400);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("uniformCount%0d(n=%0d)", i, burstCount[i]),
                  32'(burstCount[i] >= 60 && burstCount[i] <= 140), 1);
    end

    // [0,0,128,128] x200: zero-probability indices never appear
    runBurst(32'h80800000, 200);
    checkOutput("halfCount0", 32'(burstCount[0]), 0);
    checkOutput("halfCount1", 32'(burstCount[1]), 0);
    checkOutput("halfCountBoth", 32'(burstCount[2] + burstCount[3]), 200);

    // [0,90,0,180] (sum 270) x200: index 3 wins about 66% of draws
    runBurst(32'hB4005A00, 200);
    checkOutput("skewCount0", 32'(burstCount[0]), 0);
    checkOutput("skewCount2", 32'(burstCount[2]), 0);
    checkOutput($sformatf("skewCount3(n=%0d)", burstCount[3]),
                32'(burstCount[3] >= 110 && burstCount[3] <= 160), 1);

    // Reset asserted mid-SCAN clears outputs at once and emits no result
    waitReady();
    prob_in  = 32'hFF000000;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (VL + 3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstToken", 32'(token_out), 0);
    checkOutput("midRstProb", 32'(token_prob), 0);
    checkOutput("midRstZero", 32'(zero_sum), 0);
    checkOutput("midRstValid", 32'(valid_out), 0);
    checkOutput("midRstReady", 32'(ready_out), 1);
    rstPulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (valid_out === 1'b1) rstPulses++;
    end
    checkOutput("midRstNoPulse", 32'(rstPulses), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'hFF000000);
    checkOutput("afterRstToken", 32'(tok), 3);
    checkOutput("afterRstProb", 32'(tprob), 255);
    checkOutput("afterRstLatency", 32'(lat), 32'(VL + 5));

`ifdef PROB_SAMPLER_GREEDY_EN
    // Greedy [10,200,200,5]: tie resolves to index 1, fixed latency E(2*VL+1)
    greedyMode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h05C8C80A);
      checkOutput($sformatf("greedyToken%0d", i), 32'(tok), 1);
      checkOutput($sformatf("greedyProb%0d", i), 32'(tprob), 200);
      checkOutput($sformatf("greedyLatency%0d", i), 32'(lat), 32'(2 * VL + 1));
    end
    applyStimulus(32'h00000000);
    checkOutput("greedyZeroFlag", 32'(zs), 1);
    checkOutput("greedyZeroLatency", 32'(lat), 32'(2 * VL + 1));
    greedyMode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
